// File: rtl/uhci_axi_pkg.sv
// Shared definitions for the UHCI AXI front-end and the access bridge.
// Provides the read-request selector code, default widths and the bridge
// state encoding so that both FSMs agree on them.
package uhci_axi_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned MEM_AW_DEF  = 6;
    localparam int unsigned REG_SEL_DEF = 8;
    localparam int unsigned REG_AW      = 8;

    // Read mux selector value that means "single read request active".
    localparam logic [1:0] RD_REQ_CODE = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RD_ISSUE   = 2'd1,
        ST_RD_CAPTURE = 2'd2
    } bridge_state_e;

endpackage

// File: rtl/uhci_access_bridge_if.sv
// Bundle of the bridge's FIFO, read-request, register-file and USB memory
// signals.
//   master : the access bridge (pops FIFO, drives strobes and read results)
//   slave  : the surroundings (FIFO pair, read mux, register file, memory)
interface uhci_access_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MEM_AW = 6
);

    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_addr;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;

    logic [1:0]        Read_en;
    logic [ADDR_W-1:0] R_address_mux;
    logic [7:0]        r_data_reg;
    logic [DATA_W-1:0] r_data_mem;
    logic              data_reg_toggle;
    logic              data_mem_toggle;

    logic [7:0]        reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;

    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  fifo_empty, fifo_addr, fifo_data,
        input  Read_en, R_address_mux,
        input  reg_rdata, mem_rdata,
        output fifo_rd_en,
        output r_data_reg, r_data_mem, data_reg_toggle, data_mem_toggle,
        output reg_addr, reg_wdata, reg_we, reg_re,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        output fifo_empty, fifo_addr, fifo_data,
        output Read_en, R_address_mux,
        output reg_rdata, mem_rdata,
        input  fifo_rd_en,
        input  r_data_reg, r_data_mem, data_reg_toggle, data_mem_toggle,
        input  reg_addr, reg_wdata, reg_we, reg_re,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );

endinterface

// File: rtl/uhci_access_bridge.sv
// UHCI access bridge: drains posted writes from the AXI front-end's
// address/data FIFO pair into the byte-wide UHCI register file or the
// word-wide USB shared memory, and services single reads with a
// toggle-flip completion handshake. Pending writes always drain before a
// read is issued (read-after-write coherence).
// Ports:
//   Clk  : clock
//   Rst  : asynchronous active-low reset
//   bus  : master view of uhci_access_bridge_if (FIFO pop, read request
//          and results, register/memory strobes and data)
// fifo_rd_en is the only combinational output; everything else is a flop.
module uhci_access_bridge
    import uhci_axi_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_AW  = MEM_AW_DEF,
    parameter int unsigned REG_SEL = REG_SEL_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    uhci_access_bridge_if.master bus
);

    // Address bits actually decoded: byte address up to and including REG_SEL.
    localparam int unsigned DEC_W = REG_SEL + 1;

    bridge_state_e state_q, state_d;

    logic              run_q;
    logic              rd_pend_q, rd_pend_d;
    logic [DEC_W-1:0]  rd_addr_q, rd_addr_d;
    logic              rd_prev_q, rd_prev_d;

    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic [REG_AW-1:0] reg_wdata_q, reg_wdata_d;
    logic              reg_we_q, reg_we_d;
    logic              reg_re_q, reg_re_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;

    logic [REG_AW-1:0] r_data_reg_q, r_data_reg_d;
    logic [DATA_W-1:0] r_data_mem_q, r_data_mem_d;
    logic              data_reg_toggle_q, data_reg_toggle_d;
    logic              data_mem_toggle_q, data_mem_toggle_d;

    logic              req_now;
    logic              req_accept;
    logic              pop;
    logic              stage_busy;
    logic              rd_go;
    logic [DEC_W-1:0]  rd_addr_sel;
    logic              unused_addr_bits;

    // Request is a rising level of Read_en==RD_REQ_CODE; ignored while busy.
    assign req_now    = (bus.Read_en == RD_REQ_CODE);
    assign req_accept = req_now && !rd_prev_q && !rd_pend_q && (state_q == ST_IDLE);

    // run_q keeps the FIFO untouched while reset is held.
    assign pop        = run_q && (state_q == ST_IDLE) && !bus.fifo_empty;

    // The write stage is the registered we strobe with its address/data.
    assign stage_busy = reg_we_q || mem_we_q;

    // A read may only issue once the FIFO and the write stage are both empty.
    assign rd_go       = (state_q == ST_IDLE) && (rd_pend_q || req_accept)
                         && bus.fifo_empty && !stage_busy;
    assign rd_addr_sel = rd_pend_q ? rd_addr_q : bus.R_address_mux[DEC_W-1:0];

    // Next-state, strobe and result computation.
    always_comb begin
        state_d           = state_q;
        rd_pend_d         = rd_pend_q;
        rd_addr_d         = rd_addr_q;
        rd_prev_d         = req_now;
        reg_addr_d        = reg_addr_q;
        reg_wdata_d       = reg_wdata_q;
        reg_we_d          = 1'b0;
        reg_re_d          = 1'b0;
        mem_addr_d        = mem_addr_q;
        mem_wdata_d       = mem_wdata_q;
        mem_we_d          = 1'b0;
        mem_re_d          = 1'b0;
        r_data_reg_d      = r_data_reg_q;
        r_data_mem_d      = r_data_mem_q;
        data_reg_toggle_d = data_reg_toggle_q;
        data_mem_toggle_d = data_mem_toggle_q;

        if (req_accept) begin
            rd_pend_d = 1'b1;
            rd_addr_d = bus.R_address_mux[DEC_W-1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    // Writes win any same-cycle contest with a read.
                    if (bus.fifo_addr[REG_SEL]) begin
                        reg_we_d    = 1'b1;
                        reg_addr_d  = bus.fifo_addr[REG_AW-1:0];
                        reg_wdata_d = bus.fifo_data[REG_AW-1:0];
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = bus.fifo_addr[MEM_AW+1:2];
                        mem_wdata_d = bus.fifo_data;
                    end
                end else if (rd_go) begin
                    state_d = ST_RD_ISSUE;
                    if (rd_addr_sel[REG_SEL]) begin
                        reg_re_d   = 1'b1;
                        reg_addr_d = rd_addr_sel[REG_AW-1:0];
                    end else begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = rd_addr_sel[MEM_AW+1:2];
                    end
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                if (rd_addr_q[REG_SEL]) begin
                    r_data_reg_d      = bus.reg_rdata;
                    data_reg_toggle_d = !data_reg_toggle_q;
                end else begin
                    r_data_mem_d      = bus.mem_rdata;
                    data_mem_toggle_d = !data_mem_toggle_q;
                end
                rd_pend_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q           <= ST_IDLE;
            run_q             <= 1'b0;
            rd_pend_q         <= 1'b0;
            rd_addr_q         <= '0;
            rd_prev_q         <= 1'b0;
            reg_addr_q        <= '0;
            reg_wdata_q       <= '0;
            reg_we_q          <= 1'b0;
            reg_re_q          <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            mem_we_q          <= 1'b0;
            mem_re_q          <= 1'b0;
            r_data_reg_q      <= '0;
            r_data_mem_q      <= '0;
            data_reg_toggle_q <= 1'b0;
            data_mem_toggle_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            run_q             <= 1'b1;
            rd_pend_q         <= rd_pend_d;
            rd_addr_q         <= rd_addr_d;
            rd_prev_q         <= rd_prev_d;
            reg_addr_q        <= reg_addr_d;
            reg_wdata_q       <= reg_wdata_d;
            reg_we_q          <= reg_we_d;
            reg_re_q          <= reg_re_d;
            mem_addr_q        <= mem_addr_d;
            mem_wdata_q       <= mem_wdata_d;
            mem_we_q          <= mem_we_d;
            mem_re_q          <= mem_re_d;
            r_data_reg_q      <= r_data_reg_d;
            r_data_mem_q      <= r_data_mem_d;
            data_reg_toggle_q <= data_reg_toggle_d;
            data_mem_toggle_q <= data_mem_toggle_d;
        end
    end

    assign bus.fifo_rd_en      = pop;
    assign bus.reg_addr        = reg_addr_q;
    assign bus.reg_wdata       = reg_wdata_q;
    assign bus.reg_we          = reg_we_q;
    assign bus.reg_re          = reg_re_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_re          = mem_re_q;
    assign bus.r_data_reg      = r_data_reg_q;
    assign bus.r_data_mem      = r_data_mem_q;
    assign bus.data_reg_toggle = data_reg_toggle_q;
    assign bus.data_mem_toggle = data_mem_toggle_q;

    // Address bits above REG_SEL are don't-care.
    assign unused_addr_bits = ^{bus.fifo_addr[ADDR_W-1:DEC_W], bus.R_address_mux[ADDR_W-1:DEC_W]};

endmodule

// File: tb/tb_uhci_access_bridge.sv
// Bench for uhci_access_bridge: FIFO, register-file and memory models drive
// the DUT; expected bus events and read results are queued when stimulus is
// issued and a negedge monitor pops and compares them as the DUT produces them.
module tb_uhci_access_bridge;
    import uhci_axi_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MEM_AW = 6;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    uhci_access_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) bus ();

    uhci_access_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW),
        .REG_SEL(8)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    // kind: 0 reg write, 1 mem write, 2 reg read, 3 mem read
    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    ev_t         exp_ev[$];
    logic [7:0]  exp_rd_reg[$];
    logic [31:0] exp_rd_mem[$];
    wr_t         fifo_q[$];

    bit [7:0]  ref_reg[256];
    bit [31:0] ref_mem[64];
    bit [7:0]  dev_reg[256];
    bit [31:0] dev_mem[64];

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- models ----------------
    function automatic void fifo_refresh();
        bus.fifo_empty = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) begin
            bus.fifo_addr = fifo_q[0].a;
            bus.fifo_data = fifo_q[0].d;
        end
    endfunction

    initial begin : fifo_proc
        wr_t popped;
        bit  do_pop;
        forever begin
            @(posedge Clk);
            do_pop = bus.fifo_rd_en;
            #1;
            if (do_pop && fifo_q.size() != 0) begin
                popped = fifo_q.pop_front();
                fifo_refresh();
            end
        end
    end

    always @(posedge Clk) begin
        if (bus.reg_we) dev_reg[bus.reg_addr] <= bus.reg_wdata;
        if (bus.reg_re) bus.reg_rdata <= dev_reg[bus.reg_addr];
        if (bus.mem_we) dev_mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= dev_mem[bus.mem_addr];
    end

    // ---------------- monitor ----------------
    bit          prev_rt, prev_mt;
    int          m_nstb, a_kind;
    logic [7:0]  a_addr;
    logic [31:0] a_data;
    ev_t         m_e;
    logic [7:0]  m_er;
    logic [31:0] m_em;

    always @(negedge Clk) begin
        if (!Rst) begin
            prev_rt = 1'b0;
            prev_mt = 1'b0;
        end else begin
            m_nstb = int'(bus.reg_we) + int'(bus.reg_re) + int'(bus.mem_we) + int'(bus.mem_re);
            if (m_nstb != 0) begin
                n_cmp++;
                if (m_nstb > 1) begin
                    n_err++;
                    $display("FAIL strobe_excl: %0d strobes active, required 1", m_nstb);
                end
                if (bus.reg_we)      begin a_kind = 0; a_addr = bus.reg_addr;      a_data = {24'h0, bus.reg_wdata}; end
                else if (bus.mem_we) begin a_kind = 1; a_addr = 8'(bus.mem_addr); a_data = bus.mem_wdata; end
                else if (bus.reg_re) begin a_kind = 2; a_addr = bus.reg_addr;      a_data = 32'h0; end
                else                 begin a_kind = 3; a_addr = 8'(bus.mem_addr); a_data = 32'h0; end
                n_cmp++;
                if (exp_ev.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_strobe: kind %0d addr %h, required none", a_kind, a_addr);
                end else begin
                    m_e = exp_ev.pop_front();
                    if (m_e.kind != a_kind || m_e.addr != a_addr || m_e.data != a_data) begin
                        n_err++;
                        $display("FAIL bus_event: got kind %0d addr %h data %h, required kind %0d addr %h data %h",
                                 a_kind, a_addr, a_data, m_e.kind, m_e.addr, m_e.data);
                    end
                end
            end
            if (bus.data_reg_toggle != prev_rt) begin
                prev_rt = bus.data_reg_toggle;
                n_cmp++;
                if (exp_rd_reg.size() == 0) begin
                    n_err++;
                    $display("FAIL reg_toggle: unexpected flip, r_data_reg %h", bus.r_data_reg);
                end else begin
                    m_er = exp_rd_reg.pop_front();
                    if (bus.r_data_reg != m_er) begin
                        n_err++;
                        $display("FAIL r_data_reg: got %h, required %h", bus.r_data_reg, m_er);
                    end
                end
            end
            if (bus.data_mem_toggle != prev_mt) begin
                prev_mt = bus.data_mem_toggle;
                n_cmp++;
                if (exp_rd_mem.size() == 0) begin
                    n_err++;
                    $display("FAIL mem_toggle: unexpected flip, r_data_mem %h", bus.r_data_mem);
                end else begin
                    m_em = exp_rd_mem.pop_front();
                    if (bus.r_data_mem != m_em) begin
                        n_err++;
                        $display("FAIL r_data_mem: got %h, required %h", bus.r_data_mem, m_em);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        int  idx;
        fifo_q.push_back('{a: a, d: d});
        fifo_refresh();
        if (((a >> 8) & 1) == 1) begin
            idx = int'(a & 32'hFF);
            ref_reg[idx] = d[7:0];
            e = '{kind: 0, addr: 8'(idx), data: {24'h0, d[7:0]}};
        end else begin
            idx = int'((a >> 2) & 32'h3F);
            ref_mem[idx] = d;
            e = '{kind: 1, addr: 8'(idx), data: d};
        end
        exp_ev.push_back(e);
    endtask

    task automatic do_read(input logic [31:0] a, input bit chk_lat);
        int  idx, cnt;
        bit  is_reg, done;
        bit  rt0, mt0;
        if (bus.Read_en == RD_REQ_CODE) begin
            bus.Read_en = 2'b00;
            tick();
        end
        is_reg = (((a >> 8) & 1) == 1);
        if (is_reg) begin
            idx = int'(a & 32'hFF);
            exp_ev.push_back('{kind: 2, addr: 8'(idx), data: 32'h0});
            exp_rd_reg.push_back(ref_reg[idx]);
        end else begin
            idx = int'((a >> 2) & 32'h3F);
            exp_ev.push_back('{kind: 3, addr: 8'(idx), data: 32'h0});
            exp_rd_mem.push_back(ref_mem[idx]);
        end
        rt0 = bus.data_reg_toggle;
        mt0 = bus.data_mem_toggle;
        bus.R_address_mux = a;
        bus.Read_en       = RD_REQ_CODE;
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 300) begin
            tick();
            cnt++;
            if (bus.data_reg_toggle != rt0 || bus.data_mem_toggle != mt0) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL read_timeout: addr %h no toggle after %0d cycles", a, cnt);
        end else begin
            if (chk_lat) check("read_latency", 64'(cnt), 64'd3);
            if (is_reg) check("mem_toggle_untouched", 64'(bus.data_mem_toggle), 64'(mt0));
            else        check("reg_toggle_untouched", 64'(bus.data_reg_toggle), 64'(rt0));
        end
    endtask

    function automatic logic [31:0] gen_addr();
        logic [31:0] upper, low;
        upper = $urandom & 32'hFFFF_FE00;
        if ($urandom_range(0, 1) == 1) low = 32'h100 | 32'($urandom_range(0, 15));
        else low = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        return upper | low;
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({bus.fifo_rd_en, bus.data_reg_toggle, bus.data_mem_toggle, bus.reg_we, bus.reg_re,
                    bus.mem_we, bus.mem_re, bus.reg_addr, bus.reg_wdata, bus.mem_addr})
             | 64'(bus.r_data_reg) | 64'(bus.r_data_mem) | 64'(bus.mem_wdata);
    endfunction

    // ---------------- main sequence ----------------
    initial begin : stim
        int   nw;
        logic [31:0] d10;
        bus.fifo_empty    = 1'b1;
        bus.fifo_addr     = '0;
        bus.fifo_data     = '0;
        bus.Read_en       = 2'b00;
        bus.R_address_mux = '0;
        Rst = 1'b0;
        #1;
        check("reset_outputs", all_outs(), 64'h0);
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b1;

        // Idle after reset: nothing moves.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_outputs", all_outs(), 64'h0);
        end

        // Directed writes: register then memory.
        push_wr(32'h0000_0104, 32'hDEAD_BEA5);
        push_wr(32'h0000_0008, 32'h1234_5678);
        #1;
        check("pop_comb", 64'(bus.fifo_rd_en), 64'd1);
        tick();
        check("reg_we_n1", 64'(bus.reg_we), 64'd1);
        tick();
        check("mem_we_n1", 64'(bus.mem_we), 64'd1);
        repeat (3) tick();

        // Memory read with exact latency.
        push_wr(32'h0000_000C, 32'hCAFE_F00D);
        repeat (5) tick();
        do_read(32'h0000_000C, 1'b1);
        check("r_data_mem_cafe", 64'(bus.r_data_mem), 64'hCAFE_F00D);

        // Three queued writes to 0x10 with a same-cycle read of 0x10.
        bus.Read_en = 2'b00;
        tick();
        d10 = 32'h0;
        for (int i = 0; i < 3; i++) begin
            d10 = $urandom;
            push_wr(32'h0000_0010, d10);
        end
        do_read(32'h0000_0010, 1'b0);
        check("raw_third_write", 64'(bus.r_data_mem), 64'(d10));

        // Back-to-back register reads; held level must not retrigger.
        repeat (3) tick();
        do_read(32'h0000_0100, 1'b1);
        repeat (10) tick();
        do_read(32'h0000_0104, 1'b1);
        check("r_data_reg_104", 64'(bus.r_data_reg), 64'h0000_00A5);

        // Reset asserted in the RD_ISSUE cycle.
        bus.Read_en = 2'b00;
        tick();
        bus.R_address_mux = 32'h0000_0020;
        bus.Read_en       = RD_REQ_CODE;
        tick();
        check("rd_issue_mem_re", 64'(bus.mem_re), 64'd1);
        Rst = 1'b0;
        exp_ev.delete();
        exp_rd_reg.delete();
        exp_rd_mem.delete();
        push_wr(32'h0000_0024, 32'h5A5A_0001);
        #1;
        check("rst_no_pop", 64'(bus.fifo_rd_en), 64'd0);
        check("rst_toggles", 64'({bus.data_reg_toggle, bus.data_mem_toggle}), 64'd0);
        check("rst_no_strobe", 64'({bus.reg_we, bus.reg_re, bus.mem_we, bus.mem_re}), 64'd0);
        bus.Read_en = 2'b00;
        tick();
        tick();
        Rst = 1'b1;
        repeat (6) tick();
        do_read(32'h0000_0024, 1'b1);

        // Randomised mix of writes and reads.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 2) != 2) begin
                nw = $urandom_range(1, 3);
                for (int k = 0; k < nw; k++) push_wr(gen_addr(), $urandom);
                repeat ($urandom_range(0, 2)) tick();
            end else begin
                if ($urandom_range(0, 1) == 1) push_wr(gen_addr(), $urandom);
                do_read(gen_addr(), 1'b0);
                case ($urandom_range(0, 3))
                    0:       bus.Read_en = 2'b00;
                    1:       bus.Read_en = 2'b10;
                    2:       bus.Read_en = 2'b11;
                    default: bus.Read_en = RD_REQ_CODE;
                endcase
                tick();
            end
        end

        bus.Read_en = 2'b00;
        repeat (30) tick();
        check("events_left", 64'(exp_ev.size()), 64'd0);
        check("reg_reads_left", 64'(exp_rd_reg.size()), 64'd0);
        check("mem_reads_left", 64'(exp_rd_mem.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
